// File: rtl/int_arbiter.sv
// int_arbiter: latches rising irq edges, filters them through a mask and grants one device ID
// per int_ack/eoi handshake. Define INT_ARBITER_ROUND_ROBIN_EN for round-robin selection (default: fixed priority).
module int_arbiter #(
   parameter  int DEV_ID_SIZE = 3,
   localparam int DEVS        = 2**DEV_ID_SIZE
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DEVS-1:0]        irq,
   input  logic                   mask_we,
   input  logic [DEVS-1:0]        mask_wdata,
   input  logic                   int_ack,
   input  logic                   eoi,
   output logic                   int_req,
   output logic [DEV_ID_SIZE-1:0] dev_id,
   output logic                   id_valid,
   output logic                   busy,
   output logic [DEVS-1:0]        pending,
   output logic [DEVS-1:0]        mask
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t                 state_r;
   logic [DEVS-1:0]        irq_q;
   logic [DEVS-1:0]        edge_s;
   logic [DEVS-1:0]        eligible_s;
   logic                   any_eligible_s;
   logic [DEV_ID_SIZE-1:0] winner_s;
   logic                   grant_s;
   logic [DEVS-1:0]        clear_s;

   assign edge_s         = irq & ~irq_q;
   assign eligible_s     = pending & ~mask;
   assign any_eligible_s = |eligible_s;
   assign grant_s        = (state_r == REQ) && int_ack && any_eligible_s;
   assign clear_s        = grant_s ? ({{(DEVS-1){1'b0}}, 1'b1} << winner_s) : {DEVS{1'b0}};

`ifdef INT_ARBITER_ROUND_ROBIN_EN
   logic [DEV_ID_SIZE-1:0] last_id;
   logic [DEV_ID_SIZE-1:0] cand_s;

   // Round-robin winner: scan offsets from far to near so the nearest eligible line after last_id sticks.
   always_comb begin
      winner_s = {DEV_ID_SIZE{1'b0}};
      cand_s   = {DEV_ID_SIZE{1'b0}};
      for (int k = DEVS; k >= 1; k--) begin
         cand_s   = last_id + DEV_ID_SIZE'(k);
         winner_s = eligible_s[cand_s] ? cand_s : winner_s;
      end
   end

   // Round-robin pointer follows every grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_id <= {DEV_ID_SIZE{1'b1}};
      end else if (grant_s) begin
         last_id <= winner_s;
      end else begin
         last_id <= last_id;
      end
   end
`else
   // Fixed-priority winner: scanning high to low leaves the lowest eligible index.
   always_comb begin
      winner_s = {DEV_ID_SIZE{1'b0}};
      for (int k = DEVS - 1; k >= 0; k--) begin
         winner_s = eligible_s[k] ? DEV_ID_SIZE'(k) : winner_s;
      end
   end
`endif

   // Edge capture, pending latch (a new edge beats a same-cycle grant clear) and mask register.
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_q   <= {DEVS{1'b0}};
         pending <= {DEVS{1'b0}};
         mask    <= {DEVS{1'b0}};
      end else begin
         irq_q   <= irq;
         pending <= (pending & ~clear_s) | edge_s;
         if (mask_we) begin
            mask <= mask_wdata;
         end else begin
            mask <= mask;
         end
      end
   end

   // Request/service handshake with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         int_req  <= 1'b0;
         id_valid <= 1'b0;
         busy     <= 1'b0;
         dev_id   <= {DEV_ID_SIZE{1'b0}};
      end else begin
         id_valid <= 1'b0;
         case (state_r)
            IDLE: begin
               if (any_eligible_s) begin
                  state_r <= REQ;
                  int_req <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            REQ: begin
               if (!any_eligible_s) begin
                  state_r <= IDLE;
                  int_req <= 1'b0;
               end else if (int_ack) begin
                  state_r  <= SERVICE;
                  int_req  <= 1'b0;
                  busy     <= 1'b1;
                  id_valid <= 1'b1;
                  dev_id   <= winner_s;
               end else begin
                  state_r <= REQ;
               end
            end
            SERVICE: begin
               if (eoi) begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end else begin
                  state_r <= SERVICE;
               end
            end
            default: begin
               state_r <= IDLE;
               int_req <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_int_arbiter.sv
// Self-checking bench for int_arbiter (DEV_ID_SIZE=3): directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_int_arbiter;

   logic       clk = 1'b0;
   logic       rst, mask_we, int_ack, eoi;
   logic [7:0] irq, mask_wdata;
   logic       int_req, id_valid, busy;
   logic [2:0] dev_id;
   logic [7:0] pending, mask;

   int checks = 0;
   int errors = 0;

   // Behavioural model: phase 0 = idle, 1 = requesting, 2 = in service
   bit [7:0] m_pending = 8'h00, m_mask = 8'h00, m_irq_q = 8'h00;
   int       m_phase = 0, m_dev_id = 0, m_last = 7;
   bit       m_id_valid = 1'b0;

   int_arbiter #(.DEV_ID_SIZE(3)) dut (
      .clk(clk), .rst(rst), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
      .int_ack(int_ack), .eoi(eoi), .int_req(int_req), .dev_id(dev_id),
      .id_valid(id_valid), .busy(busy), .pending(pending), .mask(mask)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int pick(bit [7:0] el, int last);
`ifdef INT_ARBITER_ROUND_ROBIN_EN
      for (int k = 1; k <= 8; k++) begin
         if (el[(last + k) % 8]) return (last + k) % 8;
      end
`else
      for (int i = 0; i < 8; i++) begin
         if (el[i]) return i;
      end
`endif
      return -1;
   endfunction

   task automatic tick();
      bit [7:0] el;
      int       w;
      bit       g;
      @(posedge clk);
      if (rst) begin
         m_pending = 8'h00; m_mask = 8'h00; m_irq_q = 8'h00;
         m_phase = 0; m_dev_id = 0; m_last = 7; m_id_valid = 1'b0;
      end else begin
         el = m_pending & ~m_mask;
         w  = pick(el, m_last);
         g  = (m_phase == 1) && int_ack && (el != 8'h00);
         m_id_valid = g;
         if (m_phase == 0 && el != 8'h00) m_phase = 1;
         else if (m_phase == 1 && el == 8'h00) m_phase = 0;
         else if (g) begin m_phase = 2; m_dev_id = w; m_last = w; end
         else if (m_phase == 2 && eoi) m_phase = 0;
         m_pending = (m_pending & ~(g ? 8'(1 << w) : 8'h00)) | (irq & ~m_irq_q);
         m_irq_q = irq;
         if (mask_we) m_mask = mask_wdata;
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; irq = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00; int_ack = 1'b0; eoi = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic wait_req(output bit ok);
      for (int i = 0; i < 40 && int_req !== 1'b1; i++) tick();
      ok = (int_req === 1'b1);
   endtask

   task automatic do_ack();
      int_ack = 1'b1; tick(); int_ack = 1'b0;
   endtask

   task automatic do_eoi();
      eoi = 1'b1; tick(); eoi = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; irq = 8'h81; mask_we = 1'b1; mask_wdata = 8'hFF; int_ack = 1'b1; eoi = 1'b1;
      tick(); tick();
      checks++; if (int_req !== 1'b0 || id_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_ctrl: int_req=%b id_valid=%b busy=%b, expected 0 0 0", int_req, id_valid, busy); end
      checks++; if (dev_id !== 3'd0 || pending !== 8'h00 || mask !== 8'h00) begin errors++; $display("FAIL reset_regs: dev_id=%0d pending=%h mask=%h, expected 0 00 00", dev_id, pending, mask); end
      rst = 1'b0; mask_we = 1'b0; int_ack = 1'b0; eoi = 1'b0;
      tick();
      checks++; if (pending !== 8'h81) begin errors++; $display("FAIL reset_edge: pending=%h expected 81", pending); end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      irq = 8'h20; tick();
      checks++; if (pending !== 8'h20 || int_req !== 1'b0) begin errors++; $display("FAIL single_pend: pending=%h int_req=%b expected 20 0", pending, int_req); end
      tick();
      checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL single_req: int_req=%b expected 1", int_req); end
      tick(); tick();
      do_ack();
      checks++; if (dev_id !== 3'd5 || id_valid !== 1'b1 || pending !== 8'h00 || busy !== 1'b1 || int_req !== 1'b0) begin errors++; $display("FAIL single_grant: dev_id=%0d id_valid=%b pending=%h busy=%b int_req=%b expected 5 1 00 1 0", dev_id, id_valid, pending, busy, int_req); end
      tick();
      checks++; if (id_valid !== 1'b0 || dev_id !== 3'd5 || busy !== 1'b1) begin errors++; $display("FAIL single_hold: id_valid=%b dev_id=%0d busy=%b expected 0 5 1", id_valid, dev_id, busy); end
      do_eoi();
      checks++; if (busy !== 1'b0 || dev_id !== 3'd5) begin errors++; $display("FAIL single_eoi: busy=%b dev_id=%0d expected 0 5", busy, dev_id); end
      irq = 8'h00; tick();
   endtask

   task automatic test_priority();
      bit ok;
      do_reset();
      irq = 8'h44; tick();
      wait_req(ok); do_ack();
      checks++; if (!ok || dev_id !== 3'd2) begin errors++; $display("FAIL prio_first: req_seen=%b dev_id=%0d expected 1 2", ok, dev_id); end
      do_eoi(); wait_req(ok); do_ack();
      checks++; if (!ok || dev_id !== 3'd6) begin errors++; $display("FAIL prio_second: req_seen=%b dev_id=%0d expected 1 6", ok, dev_id); end
      do_eoi(); irq = 8'h00; tick(); irq = 8'h40; tick();
      wait_req(ok); do_ack();
      checks++; if (!ok || dev_id !== 3'd6) begin errors++; $display("FAIL prio_third: req_seen=%b dev_id=%0d expected 1 6", ok, dev_id); end
      do_eoi(); irq = 8'h00; tick(); irq = 8'h44; tick();
      wait_req(ok); do_ack();
      checks++; if (!ok || dev_id !== 3'd2) begin errors++; $display("FAIL prio_wrap: req_seen=%b dev_id=%0d expected 1 2", ok, dev_id); end
      do_eoi(); irq = 8'h00; tick();
   endtask

   task automatic test_fairness();
      bit ok;
`ifdef INT_ARBITER_ROUND_ROBIN_EN
      int exp_seq[4] = '{1, 3, 1, 3};
`else
      int exp_seq[4] = '{1, 1, 1, 1};
`endif
      do_reset();
      for (int r = 0; r < 4; r++) begin
         irq = 8'h0A; tick(); irq = 8'h00; tick();
         wait_req(ok); do_ack();
         checks++; if (!ok || dev_id !== 3'(exp_seq[r])) begin errors++; $display("FAIL fair_round%0d: req_seen=%b dev_id=%0d expected 1 %0d", r, ok, dev_id, exp_seq[r]); end
         do_eoi();
      end
   endtask

   task automatic test_mask();
      do_reset();
      mask_we = 1'b1; mask_wdata = 8'h08; tick(); mask_we = 1'b0;
      checks++; if (mask !== 8'h08) begin errors++; $display("FAIL mask_load: mask=%h expected 08", mask); end
      irq = 8'h08; tick(); tick(); tick();
      checks++; if (pending !== 8'h08 || int_req !== 1'b0) begin errors++; $display("FAIL mask_block: pending=%h int_req=%b expected 08 0", pending, int_req); end
      mask_we = 1'b1; mask_wdata = 8'h00; tick(); mask_we = 1'b0;
      checks++; if (int_req !== 1'b0 || mask !== 8'h00) begin errors++; $display("FAIL mask_clear1: int_req=%b mask=%h expected 0 00", int_req, mask); end
      tick();
      checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL mask_clear2: int_req=%b expected 1", int_req); end
   endtask

   task automatic test_mask_cancel();
      do_reset();
      irq = 8'h10; tick(); tick();
      checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL cancel_req: int_req=%b expected 1", int_req); end
      mask_we = 1'b1; mask_wdata = 8'h10; tick(); mask_we = 1'b0;
      tick();
      checks++; if (int_req !== 1'b0 || pending !== 8'h10 || busy !== 1'b0) begin errors++; $display("FAIL cancel_drop: int_req=%b pending=%h busy=%b expected 0 10 0", int_req, pending, busy); end
      do_ack();
      checks++; if (id_valid !== 1'b0 || int_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL cancel_idle_ack: id_valid=%b int_req=%b busy=%b expected 0 0 0", id_valid, int_req, busy); end
   endtask

   task automatic test_reset_abort();
      do_reset();
      irq = 8'h01; tick(); irq = 8'h00; tick();
      int_ack = 1'b1; irq = 8'h01; tick(); int_ack = 1'b0;
      checks++; if (pending !== 8'h01 || dev_id !== 3'd0 || id_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL abort_grant: pending=%h dev_id=%0d id_valid=%b busy=%b expected 01 0 1 1", pending, dev_id, id_valid, busy); end
      tick();
      rst = 1'b1; irq = 8'h00; tick();
      checks++; if (int_req !== 1'b0 || id_valid !== 1'b0 || busy !== 1'b0 || pending !== 8'h00 || mask !== 8'h00 || dev_id !== 3'd0) begin errors++; $display("FAIL abort_rst: int_req=%b id_valid=%b busy=%b pending=%h mask=%h dev_id=%0d expected all 0", int_req, id_valid, busy, pending, mask, dev_id); end
      rst = 1'b0; tick();
      checks++; if (id_valid !== 1'b0 || int_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_after: id_valid=%b int_req=%b busy=%b expected 0 0 0", id_valid, int_req, busy); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 2) == 0) irq = irq ^ 8'(1 << $urandom_range(0, 7));
         mask_we    = ($urandom_range(0, 15) == 0);
         mask_wdata = 8'($urandom) & 8'($urandom);
         int_ack    = ($urandom_range(0, 2) == 0);
         eoi        = ($urandom_range(0, 3) == 0);
         rst        = ($urandom_range(0, 150) == 0);
         tick();
         checks++; if (int_req !== (m_phase == 1) || busy !== (m_phase == 2)) begin errors++; $display("FAIL rand_ctrl c=%0d: int_req=%b busy=%b expected phase %0d", c, int_req, busy, m_phase); end
         checks++; if (id_valid !== m_id_valid || dev_id !== 3'(m_dev_id)) begin errors++; $display("FAIL rand_grant c=%0d: id_valid=%b dev_id=%0d expected %b %0d", c, id_valid, dev_id, m_id_valid, m_dev_id); end
         checks++; if (pending !== m_pending || mask !== m_mask) begin errors++; $display("FAIL rand_regs c=%0d: pending=%h mask=%h expected %h %h", c, pending, mask, m_pending, m_mask); end
      end
      rst = 1'b0; int_ack = 1'b0; eoi = 1'b0; mask_we = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_fairness();
      test_mask();
      test_mask_cancel();
      test_reset_abort();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
